// File: rtl/cim_ibuf_rx.sv
// Input buffer in front of one CIM tile: captures the controller's row writes,
// then replays the stored vector into the crossbar as LSB-first bit-planes.
module cim_ibuf_rx #(
   parameter int datatype_size = 8,
   parameter int xbar_size     = 256,
   localparam int addr_w = (xbar_size > 1) ? $clog2(xbar_size) : 1,
   localparam int bit_w  = (datatype_size > 1) ? $clog2(datatype_size) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_cim_we,
   input  logic [addr_w-1:0]    i_cim_addr,
   input  logic [datatype_size-1:0] i_data,
   input  logic                 i_ctrl_busy,
   output logic                 o_cim_busy,
   output logic [xbar_size-1:0] o_wl,
   output logic                 o_wl_valid,
   input  logic                 i_xbar_ready,
   output logic [bit_w-1:0]     o_bit_idx,
   input  logic                 i_xbar_busy,
   output logic                 o_done,
   output logic                 o_overrun
);

   // state    | meaning
   // st_idle  | nothing loaded, waiting for the first write
   // st_load  | collecting writes until the controller drops busy
   // st_fire  | presenting bit-planes o_bit_idx = 0..datatype_size-1
   // st_drain | last plane accepted, waiting for the crossbar to finish
   localparam logic [1:0] st_idle  = 2'd0;
   localparam logic [1:0] st_load  = 2'd1;
   localparam logic [1:0] st_fire  = 2'd2;
   localparam logic [1:0] st_drain = 2'd3;

   logic [1:0]               state;
   logic [xbar_size-1:0]     valid;
   logic [datatype_size-1:0] mem [xbar_size];
   logic                     in_range;
   logic                     wr_hit;
   logic                     wr_accept;
   logic                     last_plane;

   generate
      if (xbar_size == (1 << addr_w)) begin : g_pow2
         assign in_range = 1'b1;
      end else begin : g_npow2
         assign in_range = (i_cim_addr < addr_w'(xbar_size));
      end
   endgenerate

   assign o_cim_busy = (state == st_fire) || (state == st_drain);
   assign o_wl_valid = (state == st_fire);
   assign wr_hit     = i_cim_we && in_range;
   assign wr_accept  = wr_hit && !o_cim_busy;
   assign last_plane = (o_bit_idx == bit_w'(datatype_size - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= st_idle;
         valid     <= '0;
         o_bit_idx <= '0;
         o_done    <= 1'b0;
         o_overrun <= 1'b0;
      end else begin
         o_done <= 1'b0;
         if (wr_accept) valid[i_cim_addr] <= 1'b1;
         if (wr_hit && o_cim_busy) o_overrun <= 1'b1;
         case (state)
            st_idle: begin
               if (wr_accept) state <= st_load;
            end
            st_load: begin
               if (!i_ctrl_busy) begin
                  state     <= st_fire;
                  o_bit_idx <= '0;
               end
            end
            st_fire: begin
               if (i_xbar_ready) begin
                  if (last_plane) state <= st_drain;
                  else            o_bit_idx <= o_bit_idx + 1'b1;
               end
            end
            st_drain: begin
               if (!i_xbar_busy) begin
                  o_done    <= 1'b1;
                  valid     <= '0;
                  o_bit_idx <= '0;
                  state     <= st_idle;
               end
            end
            default: state <= st_idle;
         endcase
      end
   end

   // Storage is never reset; the valid mask hides stale contents.
   always_ff @(posedge clk) begin
      if (wr_accept) mem[i_cim_addr] <= i_data;
   end

   always_comb begin
      o_wl = '0;
      for (int r = 0; r < xbar_size; r++) begin
         o_wl[r] = valid[r] & mem[r][o_bit_idx];
      end
   end

endmodule
